// File: rtl/lib_uart_pkg.sv
// Shared UART receive types and constants.
// Imported by uart_rx_buf and uart_rx_fifo.
package lib_uart;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } RX_STATE;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE      = 1'b1;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO for the UART receiver.
// Pointers carry one extra wrap bit so full/empty need no occupancy counter.
module uart_rx_fifo
    import lib_uart::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [UART_DATA_BITS-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [UART_DATA_BITS-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]          entry_we;
    logic                      do_push;
    logic                      do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q == {~rd_ptr_q[PW-1], rd_ptr_q[AW-1:0]});
        do_pop   = pop & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = do_push & (wr_ptr_q[AW-1:0] == AW'(gi));
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = entry_we[i] ? push_data : mem_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver with a receive buffer for the CPU R_IO read path.
// Define UART_RX_FIFO_EN for a DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_rx_buf
    import lib_uart::*;
#(
    parameter int WAIT  = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      uart_rx,
    input  logic                      rd_en,
    output logic [UART_DATA_BITS-1:0] rd_data,
    output logic                      rd_valid,
    output logic                      overrun,
    output logic                      frame_err,
    input  logic                      clr_err
);

    localparam int CW = $clog2(WAIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(WAIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(WAIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);
    localparam bit PARAMS_OK = (WAIT >= 4) && (WAIT % 2 == 0) &&
                               (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0);

    logic                      rx_meta_q, rx_meta_d;
    logic                      rx_s_q, rx_s_d;
    RX_STATE                   state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      overrun_q, overrun_d;
    logic                      frame_err_q, frame_err_d;
    logic                      push_req;
    logic                      ferr_set;
    logic                      ovr_set;
    logic                      buf_full;
    logic                      buf_valid;

    always_comb begin
        rx_meta_d = uart_rx;
        rx_s_d    = rx_meta_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        ferr_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a stuck-low line cannot retrigger.
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ovr_set     = push_req & buf_full & ~rd_en;
        overrun_d   = ovr_set  | (overrun_q   & ~clr_err);
        frame_err_d = ferr_set | (frame_err_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q   <= UART_IDLE;
            rx_s_q      <= UART_IDLE;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic fifo_empty;

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (shift_q),
        .pop       (rd_en),
        .full      (buf_full),
        .empty     (fifo_empty),
        .head      (rd_data)
    );

    assign buf_valid = ~fifo_empty;
`else
    logic [UART_DATA_BITS-1:0] hold_q, hold_d;
    logic                      hold_vld_q, hold_vld_d;
    logic                      hold_push;
    logic                      hold_pop;

    always_comb begin
        hold_pop   = rd_en & hold_vld_q;
        hold_push  = push_req & (~hold_vld_q | hold_pop);
        hold_d     = hold_push ? shift_q : hold_q;
        hold_vld_d = hold_push | (hold_vld_q & ~hold_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    assign buf_full  = hold_vld_q;
    assign buf_valid = hold_vld_q;
    assign rd_data   = hold_q;
`endif

    // A misconfigured instance never presents data.
    assign rd_valid  = buf_valid & PARAMS_OK;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule
